// File: rtl/elc3_bus_pkg.sv
// Shared types and constants for the SRAM-style bus target.
package elc3_bus_pkg;

  localparam int BUS_N = 16;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    READ_DRIVE,
    TURNAROUND
  } bus_tgt_state_t;

endpackage

// File: rtl/sram_bus_target_if.sv
// Shared 16-bit bidirectional bus: strobes, address, tri-state data and target status.
interface sram_bus_target_if
  import elc3_bus_pkg::*;
#(
  parameter int N = BUS_N,
  parameter int A = 8
);
  logic         CE_N;
  logic         OE_N;
  logic         WE_N;
  logic [A-1:0] Addr;
  wire  [N-1:0] Data;
  logic         Drive;
  logic         Busy;
  logic [N-1:0] data_tgt;
  logic [N-1:0] data_mst;
  logic         mst_oe;

  // Target has priority; overlap is a bus error that the initiator must avoid.
  assign Data = Drive ? data_tgt : (mst_oe ? data_mst : {N{1'bz}});

  modport slave (
    input  CE_N, OE_N, WE_N, Addr, Data,
    output Drive, Busy, data_tgt
  );

  modport master (
    output CE_N, OE_N, WE_N, Addr, data_mst, mst_oe,
    input  Data, Drive, Busy
  );
endinterface

// File: rtl/bus_sample_reg.sv
// One register stage on the incoming strobes, address and data.
module bus_sample_reg #(
  parameter int N = 16,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce_n,
  input  logic         oe_n,
  input  logic         we_n,
  input  logic [A-1:0] addr,
  input  logic [N-1:0] data,
  output logic         ce_q,
  output logic         oe_q,
  output logic         we_q,
  output logic [A-1:0] addr_q,
  output logic [N-1:0] data_q
);
  // Strobes are stored as active-high "asserted" flags so the cleared state means idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ce_q   <= 1'b0;
      oe_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ce_q   <= ~ce_n;
      oe_q   <= ~oe_n;
      we_q   <= ~we_n;
      addr_q <= addr;
      data_q <= data;
    end
  end
endmodule

// File: rtl/sram_bus_target.sv
// Asynchronous-SRAM-style bus target with registered strobes, fixed read latency
// and a forced turnaround cycle after every driven read.
//
// state      | meaning
// IDLE       | waiting for a sampled write or read request
// WRITE      | tracking address/data while WE is held; commits on release
// READ_WAIT  | counting down the access latency for rd_addr
// READ_DRIVE | driving drive_reg onto Data
// TURNAROUND | bus released for one cycle before accepting new requests
module sram_bus_target
  import elc3_bus_pkg::*;
#(
  parameter int N        = BUS_N,
  parameter int A        = 8,
  parameter int READ_LAT = 2
) (
  input logic               Clk,
  input logic               Reset,
  sram_bus_target_if.slave  bus
);
  localparam int            CW       = $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LAT - 1);

  logic           ce_q, oe_q, we_q;
  logic [A-1:0]   addr_q;
  logic [N-1:0]   data_q;
  bus_tgt_state_t state;
  logic [A-1:0]   rd_addr, wr_addr;
  logic [N-1:0]   wr_data, drive_reg;
  logic [CW-1:0]  cnt;
  logic           drive, busy;
  logic           wr_req, rd_req, wr_commit;
  logic [N-1:0]   mem [2**A];

  bus_sample_reg #(.N(N), .A(A)) u_sample (
    .clk    (Clk),
    .reset  (Reset),
    .ce_n   (bus.CE_N),
    .oe_n   (bus.OE_N),
    .we_n   (bus.WE_N),
    .addr   (bus.Addr),
    .data   (bus.Data),
    .ce_q   (ce_q),
    .oe_q   (oe_q),
    .we_q   (we_q),
    .addr_q (addr_q),
    .data_q (data_q)
  );

  // A sampled write request always wins over a read request.
  assign wr_req    = ce_q & we_q;
  assign rd_req    = ce_q & oe_q & ~we_q;
  assign wr_commit = (state == WRITE) & ~wr_req;

  always_ff @(posedge Clk) begin
    if (Reset && wr_commit) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      drive     <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      drive_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            state   <= WRITE;
            busy    <= 1'b1;
            wr_addr <= addr_q;
            wr_data <= data_q;
          end else if (rd_req) begin
            state   <= READ_WAIT;
            busy    <= 1'b1;
            rd_addr <= addr_q;
            cnt     <= CNT_LOAD;
          end
        end
        WRITE: begin
          if (wr_req) begin
            wr_addr <= addr_q;
            wr_data <= data_q;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        READ_WAIT: begin
          if (!rd_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (addr_q != rd_addr) begin
            rd_addr <= addr_q;
            cnt     <= CNT_LOAD;
          end else if (cnt == '0) begin
            state     <= READ_DRIVE;
            drive     <= 1'b1;
            drive_reg <= mem[rd_addr];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        READ_DRIVE: begin
          if (addr_q != rd_addr) begin
            state   <= READ_WAIT;
            drive   <= 1'b0;
            rd_addr <= addr_q;
            cnt     <= CNT_LOAD;
          end else if (!rd_req) begin
            state <= TURNAROUND;
            drive <= 1'b0;
          end
        end
        TURNAROUND: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          drive <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Drive    = drive;
  assign bus.Busy     = busy;
  assign bus.data_tgt = drive_reg;
endmodule

// File: tb/tb_sram_bus_target.sv
// Directed bench for sram_bus_target: literal timing/data checks plus a
// per-cycle comparison of driven data against a word-level memory model.
module tb_sram_bus_target;
  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] model_mem [256];
  logic [7:0]  exp_addr = 8'h00;

  sram_bus_target_if #(.N(16), .A(8)) bus ();

  sram_bus_target #(.N(16), .A(8), .READ_LAT(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.CE_N = 1'b1;
    bus.OE_N = 1'b1;
    bus.WE_N = 1'b1;
    bus.mst_oe = 1'b0;
  endtask

  // WE held low for n cycles; the last low cycle carries d_last, which must be committed.
  task automatic do_write(input logic [7:0] addr, input logic [15:0] d_first,
                          input logic [15:0] d_last, input int n, input logic with_oe);
    bus.Addr = addr;
    bus.CE_N = 1'b0;
    bus.WE_N = 1'b0;
    bus.OE_N = ~with_oe;
    bus.mst_oe = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.data_mst = (i == n - 1) ? d_last : d_first;
      step();
      check("wr_no_drive", {31'd0, bus.Drive}, 32'd0);
    end
    idle_bus();
    step();
    check("wr_busy_m", {31'd0, bus.Busy}, 32'd1);
    step();
    check("wr_idle_m1", {31'd0, bus.Busy}, 32'd0);
    model_mem[addr] = d_last;
  endtask

  task automatic read_to_drive(input logic [7:0] addr, input logic [15:0] lit);
    exp_addr = addr;
    bus.Addr = addr;
    bus.CE_N = 1'b0;
    bus.OE_N = 1'b0;
    bus.WE_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_lat_low", {31'd0, bus.Drive}, 32'd0);
    end
    step();
    check("rd_drive_k3", {31'd0, bus.Drive}, 32'd1);
    check("rd_data_lit", {16'd0, bus.Data}, {16'd0, lit});
  endtask

  task automatic do_release();
    idle_bus();
    step();
    check("rel_drive_m", {31'd0, bus.Drive}, 32'd1);
    step();
    check("rel_drive_m1", {31'd0, bus.Drive}, 32'd0);
    check("rel_turn_busy", {31'd0, bus.Busy}, 32'd1);
    step();
    check("rel_idle_m2", {31'd0, bus.Busy}, 32'd0);
  endtask

  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      check("no_contention", {31'd0, bus.Drive & bus.mst_oe}, 32'd0);
      check("drive_implies_busy", {31'd0, bus.Drive & ~bus.Busy}, 32'd0);
      if (bus.Drive) check("model_data", {16'd0, bus.Data}, {16'd0, model_mem[exp_addr]});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    bus.Addr = 8'h00;
    bus.data_mst = 16'h0000;
    Reset = 1'b0;
    step();
    step();
    check("rst_drive", {31'd0, bus.Drive}, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    Reset = 1'b1;
    step();
    check("post_rst_idle", {31'd0, bus.Busy}, 32'd0);

    // Write then read, data changes only on the last low cycle.
    do_write(8'h12, 16'h0000, 16'hBEEF, 3, 1'b0);
    check("model_pin_12", {16'd0, model_mem[8'h12]}, 32'h0000BEEF);
    read_to_drive(8'h12, 16'hBEEF);
    do_release();

    // Read abort during the wait.
    exp_addr = 8'h12;
    bus.Addr = 8'h12;
    bus.CE_N = 1'b0;
    bus.OE_N = 1'b0;
    step();
    step();
    check("abort_busy", {31'd0, bus.Busy}, 32'd1);
    bus.OE_N = 1'b1;
    step();
    check("abort_no_drive", {31'd0, bus.Drive}, 32'd0);
    step();
    check("abort_idle", {31'd0, bus.Busy}, 32'd0);
    check("abort_no_drive2", {31'd0, bus.Drive}, 32'd0);
    idle_bus();
    step();

    // Address change while driving.
    do_write(8'h10, 16'h1111, 16'h1111, 1, 1'b0);
    do_write(8'h11, 16'h2222, 16'h2222, 1, 1'b0);
    read_to_drive(8'h10, 16'h1111);
    bus.Addr = 8'h11;
    step();
    check("achg_old_drive", {31'd0, bus.Drive}, 32'd1);
    check("achg_old_data", {16'd0, bus.Data}, 32'h00001111);
    step();
    exp_addr = 8'h11;
    check("achg_gap1", {31'd0, bus.Drive}, 32'd0);
    step();
    check("achg_gap2", {31'd0, bus.Drive}, 32'd0);
    step();
    check("achg_new_drive", {31'd0, bus.Drive}, 32'd1);
    check("achg_new_data", {16'd0, bus.Data}, 32'h00002222);
    do_release();

    // WE dominates OE.
    do_write(8'h03, 16'h5A5A, 16'h5A5A, 1, 1'b1);
    read_to_drive(8'h03, 16'h5A5A);
    do_release();

    // Reset while driving.
    read_to_drive(8'h12, 16'hBEEF);
    Reset = 1'b0;
    step();
    check("rst_rd_drive", {31'd0, bus.Drive}, 32'd0);
    check("rst_rd_busy", {31'd0, bus.Busy}, 32'd0);
    idle_bus();
    Reset = 1'b1;
    step();

    // Reset while writing: store keeps 0xBEEF.
    bus.Addr = 8'h12;
    bus.CE_N = 1'b0;
    bus.WE_N = 1'b0;
    bus.mst_oe = 1'b1;
    bus.data_mst = 16'h0BAD;
    step();
    step();
    check("rst_wr_busy", {31'd0, bus.Busy}, 32'd1);
    step();
    Reset = 1'b0;
    step();
    check("rst_wr_idle", {31'd0, bus.Busy}, 32'd0);
    idle_bus();
    step();
    Reset = 1'b1;
    step();
    step();
    read_to_drive(8'h12, 16'hBEEF);
    do_release();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
